fifo_tlp: RTL and testbench

FIFO_TLP -- requirements
Module: fifo_tlp

---
 rtl/fifo_tlp.sv | 85 ++++++++
 tb/tb_fifo_tlp.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_tlp.sv
// Synchronous single-clock FIFO with registered read port, programmable
// almost-full/almost-empty thresholds and a sticky overflow/underflow flag.
module fifo_tlp #(
    parameter int DATA_WIDTH = 6,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_enable,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rd_enable,
    input  logic [ADDR_WIDTH:0]   umbral_alto,
    input  logic [ADDR_WIDTH:0]   umbral_bajo,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  FIFOempty,
    output logic                  FIFOfull,
    output logic                  FIFOpause,
    output logic                  FIFOcontinue,
    output logic                  FIFOerror
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FULL_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count;

    logic push_ok;
    logic pop_ok;
    logic overflow;
    logic underflow;

    // Request semantics: wr_enable/rd_enable are one-cycle requests with no
    // back-pressure; a request the FIFO cannot honour is dropped and latched
    // as an error. A pop frees a slot for a push on the same edge when full,
    // but an empty FIFO never forwards the word being pushed.
    assign pop_ok    = rd_enable && (count != '0);
    assign push_ok   = wr_enable && ((count != FULL_COUNT) || pop_ok);
    assign overflow  = wr_enable && !push_ok;
    assign underflow = rd_enable && !pop_ok;

    // Storage is deliberately left out of reset; the count guards every read.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
            FIFOerror <= 1'b0;
        end else begin
            valid_out <= pop_ok;
            if (pop_ok) begin
                data_out <= mem[rd_ptr];
                rd_ptr   <= rd_ptr + 1'b1;
            end
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (overflow || underflow) begin
                FIFOerror <= 1'b1;
            end
        end
    end

    assign FIFOempty    = (count == '0);
    assign FIFOfull     = (count == FULL_COUNT);
    assign FIFOpause    = (count >= umbral_alto);
    assign FIFOcontinue = (count <= umbral_bajo);

endmodule

// File: tb/tb_fifo_tlp.sv
// Self-checking bench for fifo_tlp: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_fifo_tlp;

    localparam int DW    = 6;
    localparam int AW    = 3;
    localparam int DEPTH = 8;

    logic          clk;
    logic          reset;
    logic          wr_enable;
    logic [DW-1:0] data_in;
    logic          rd_enable;
    logic [AW:0]   umbral_alto;
    logic [AW:0]   umbral_bajo;
    logic [DW-1:0] data_out;
    logic          valid_out;
    logic          FIFOempty;
    logic          FIFOfull;
    logic          FIFOpause;
    logic          FIFOcontinue;
    logic          FIFOerror;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] exp_dout;
    logic          exp_valid;
    logic          exp_err;

    fifo_tlp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_enable    (wr_enable),
        .data_in      (data_in),
        .rd_enable    (rd_enable),
        .umbral_alto  (umbral_alto),
        .umbral_bajo  (umbral_bajo),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .FIFOempty    (FIFOempty),
        .FIFOfull     (FIFOfull),
        .FIFOpause    (FIFOpause),
        .FIFOcontinue (FIFOcontinue),
        .FIFOerror    (FIFOerror)
    );

    // clock / watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // driver: call at a falling edge; returns at the next falling edge with
    // the model advanced by the rising edge in between
    task automatic step(input logic wr, input logic [DW-1:0] din, input logic rd);
        bit pop_ok;
        bit push_ok;
        wr_enable = wr;
        data_in   = din;
        rd_enable = rd;
        @(posedge clk);
        pop_ok  = rd && (exp_q.size() > 0);
        push_ok = wr && ((exp_q.size() < DEPTH) || pop_ok);
        exp_valid = pop_ok;
        if (pop_ok) exp_dout = exp_q.pop_front();
        if (push_ok) exp_q.push_back(din);
        if ((wr && !push_ok) || (rd && !pop_ok)) exp_err = 1'b1;
        @(negedge clk);
        wr_enable = 1'b0;
        rd_enable = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset     = 1'b0;
        wr_enable = 1'b0;
        rd_enable = 1'b0;
        data_in   = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        exp_dout  = '0;
        exp_valid = 1'b0;
        exp_err   = 1'b0;
    endtask

    task automatic test_reset();
        umbral_alto = 4'd0;
        umbral_bajo = 4'd2;
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_checks++;
        if ({data_out, valid_out, FIFOerror, FIFOempty, FIFOfull, FIFOpause, FIFOcontinue}
            !== {6'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1}) begin
            n_errors++;
            $display("FAIL reset_outputs: got dout=%h v=%b err=%b e=%b f=%b p=%b c=%b, want 00 0 0 1 0 1 1",
                     data_out, valid_out, FIFOerror, FIFOempty, FIFOfull, FIFOpause, FIFOcontinue);
        end
        umbral_alto = 4'd6;
        apply_reset();
        n_checks++;
        if ({FIFOempty, FIFOcontinue, FIFOpause, FIFOerror} !== 4'b1100) begin
            n_errors++;
            $display("FAIL idle_flags: got e=%b c=%b p=%b err=%b, want 1 1 0 0",
                     FIFOempty, FIFOcontinue, FIFOpause, FIFOerror);
        end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 6; i++) begin
            step(1'b1, DW'(i), 1'b0);
            n_checks++;
            if (FIFOempty !== 1'b0 || FIFOfull !== 1'b0) begin
                n_errors++;
                $display("FAIL fill_empty_full count=%0d: got e=%b f=%b, want 0 0", i, FIFOempty, FIFOfull);
            end
            n_checks++;
            if (FIFOcontinue !== (i <= 2) || FIFOpause !== (i >= 6)) begin
                n_errors++;
                $display("FAIL fill_thresholds count=%0d: got c=%b p=%b, want %b %b",
                         i, FIFOcontinue, FIFOpause, (i <= 2), (i >= 6));
            end
        end
    endtask

    task automatic test_overflow();
        step(1'b1, 6'h07, 1'b0);
        step(1'b1, 6'h08, 1'b0);
        n_checks++;
        if (FIFOfull !== 1'b1 || FIFOerror !== 1'b0) begin
            n_errors++;
            $display("FAIL full_at_8: got f=%b err=%b, want 1 0", FIFOfull, FIFOerror);
        end
        step(1'b1, 6'h3F, 1'b0);
        n_checks++;
        if (FIFOfull !== 1'b1 || FIFOerror !== 1'b1) begin
            n_errors++;
            $display("FAIL overflow_err: got f=%b err=%b, want 1 1", FIFOfull, FIFOerror);
        end
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0);
        n_checks++;
        if (FIFOerror !== 1'b1) begin
            n_errors++;
            $display("FAIL err_sticky: got %b, want 1", FIFOerror);
        end
    endtask

    task automatic test_drain();
        logic [DW-1:0] want;
        for (int i = 0; i < 8; i++) begin
            want = (i < 6) ? DW'(i + 1) : DW'(i + 1);
            step(1'b0, '0, 1'b1);
            n_checks++;
            if (data_out !== want || valid_out !== 1'b1) begin
                n_errors++;
                $display("FAIL drain_word %0d: got %h v=%b, want %h v=1", i, data_out, valid_out, want);
            end
            step(1'b0, '0, 1'b0);
            n_checks++;
            if (valid_out !== 1'b0 || data_out !== want) begin
                n_errors++;
                $display("FAIL drain_valid_pulse %0d: got %h v=%b, want %h v=0", i, data_out, valid_out, want);
            end
        end
        n_checks++;
        if (FIFOempty !== 1'b1 || FIFOerror !== 1'b1) begin
            n_errors++;
            $display("FAIL drain_end: got e=%b err=%b, want 1 1", FIFOempty, FIFOerror);
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] oldest;
        logic [DW-1:0] got;
        apply_reset();
        for (int i = 0; i < DEPTH; i++) step(1'b1, DW'($urandom_range(0, 63)), 1'b0);
        oldest = exp_q[0];
        step(1'b1, 6'h15, 1'b1);
        n_checks++;
        if (data_out !== oldest || valid_out !== 1'b1 || FIFOfull !== 1'b1 || FIFOerror !== 1'b0) begin
            n_errors++;
            $display("FAIL full_push_pop: got %h v=%b f=%b err=%b, want %h 1 1 0",
                     data_out, valid_out, FIFOfull, FIFOerror, oldest);
        end
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, '0, 1'b1);
            got = data_out;
        end
        n_checks++;
        if (got !== 6'h15 || FIFOempty !== 1'b1) begin
            n_errors++;
            $display("FAIL full_push_pop_stored: got %h e=%b, want 15 1", got, FIFOempty);
        end
        step(1'b1, 6'h33, 1'b1);
        n_checks++;
        if (valid_out !== 1'b0 || FIFOerror !== 1'b1 || FIFOempty !== 1'b0 || data_out !== 6'h15) begin
            n_errors++;
            $display("FAIL empty_push_pop: got %h v=%b err=%b e=%b, want 15 0 1 0",
                     data_out, valid_out, FIFOerror, FIFOempty);
        end
        step(1'b0, '0, 1'b1);
        n_checks++;
        if (data_out !== 6'h33 || valid_out !== 1'b1 || FIFOempty !== 1'b1) begin
            n_errors++;
            $display("FAIL empty_push_pop_word: got %h v=%b e=%b, want 33 1 1", data_out, valid_out, FIFOempty);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        umbral_alto = 4'd6;
        umbral_bajo = 4'd2;
        for (int i = 0; i < 5; i++) step(1'b1, DW'(i + 9), 1'b0);
        step(1'b0, '0, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if ({data_out, valid_out, FIFOerror, FIFOempty, FIFOfull, FIFOpause, FIFOcontinue}
            !== {6'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1}) begin
            n_errors++;
            $display("FAIL async_reset: got dout=%h v=%b err=%b e=%b f=%b p=%b c=%b, want 00 0 0 1 0 0 1",
                     data_out, valid_out, FIFOerror, FIFOempty, FIFOfull, FIFOpause, FIFOcontinue);
        end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        exp_dout  = '0;
        exp_valid = 1'b0;
        exp_err   = 1'b0;
        step(1'b1, 6'h2A, 1'b0);
        step(1'b0, '0, 1'b1);
        n_checks++;
        if (data_out !== 6'h2A || valid_out !== 1'b1 || FIFOempty !== 1'b1) begin
            n_errors++;
            $display("FAIL post_reset_word: got %h v=%b e=%b, want 2a 1 1", data_out, valid_out, FIFOempty);
        end
    endtask

    task automatic test_random();
        int occ;
        apply_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (cyc % 50 == 0) begin
                umbral_alto = AW'(0) + 4'($urandom_range(0, 15));
                umbral_bajo = 4'($urandom_range(0, 15));
            end
            if (cyc == 300) apply_reset();
            step(1'($urandom_range(0, 99) < 55), DW'($urandom_range(0, 63)),
                 1'($urandom_range(0, 99) < 45));
            occ = exp_q.size();
            n_checks++;
            if (data_out !== exp_dout || valid_out !== exp_valid) begin
                n_errors++;
                $display("FAIL rand_data cyc=%0d: got %h v=%b, want %h v=%b",
                         cyc, data_out, valid_out, exp_dout, exp_valid);
            end
            n_checks++;
            if (FIFOerror !== exp_err) begin
                n_errors++;
                $display("FAIL rand_err cyc=%0d: got %b, want %b", cyc, FIFOerror, exp_err);
            end
            n_checks++;
            if (FIFOempty !== (occ == 0) || FIFOfull !== (occ == DEPTH)) begin
                n_errors++;
                $display("FAIL rand_empty_full cyc=%0d occ=%0d: got e=%b f=%b", cyc, occ, FIFOempty, FIFOfull);
            end
            n_checks++;
            if (FIFOpause !== (occ >= int'(umbral_alto)) || FIFOcontinue !== (occ <= int'(umbral_bajo))) begin
                n_errors++;
                $display("FAIL rand_thresholds cyc=%0d occ=%0d ua=%0d ub=%0d: got p=%b c=%b",
                         cyc, occ, umbral_alto, umbral_bajo, FIFOpause, FIFOcontinue);
            end
        end
    endtask

    initial begin
        reset       = 1'b1;
        wr_enable   = 1'b0;
        rd_enable   = 1'b0;
        data_in     = '0;
        umbral_alto = 4'd6;
        umbral_bajo = 4'd2;
        exp_dout    = '0;
        exp_valid   = 1'b0;
        exp_err     = 1'b0;
        test_reset();
        test_fill();
        test_overflow();
        test_drain();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
